// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA register controller: register map,
// status/CTRL bit positions, FSM state encoding and the status packer.
package rsa_pkg;

  // Register addresses
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_PLAIN   = 3'd1;
  localparam logic [2:0] ADDR_EXP     = 3'd2;
  localparam logic [2:0] ADDR_MOD     = 3'd3;
  localparam logic [2:0] ADDR_CONST   = 3'd4;
  localparam logic [2:0] ADDR_RESULT  = 3'd5;
  localparam logic [2:0] ADDR_OPCOUNT = 3'd6;
  localparam logic [2:0] ADDR_SCRATCH = 3'd7;

  // Status byte bit positions (bits 7:5 always read zero)
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_IRQEN   = 3;
  localparam int STAT_TIMEOUT = 4;

  // CTRL write bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_CLR   = 2;

  // Engine handshake FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  // Assemble the status byte from its individual flags
  function automatic logic [7:0] packStatus(input logic busy,
                                            input logic done,
                                            input logic err,
                                            input logic irqEn,
                                            input logic timeout);
    logic [7:0] s;
    s               = 8'h00;
    s[STAT_BUSY]    = busy;
    s[STAT_DONE]    = done;
    s[STAT_ERR]     = err;
    s[STAT_IRQEN]   = irqEn;
    s[STAT_TIMEOUT] = timeout;
    return s;
  endfunction

endpackage

// File: rtl/rsa_watchdog.sv
// Engine watchdog: counts enabled cycles and flags expiry on the
// TIMEOUT_CYC-th consecutive enabled cycle. Only built with RSA_TIMEOUT_EN.
module rsa_watchdog #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: clear has priority, otherwise advance while enabled
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 32'd0;
    end else if (enable_i) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of enabled cycles already completed
  assign expired_o = enable_i && (count_q == 32'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/rsa_regctrl.sv
// RSA engine register controller: SPI-facing register file, launch /
// completion handshake with the engine, status byte and interrupt.
// Optional engine watchdog is enabled by defining RSA_TIMEOUT_EN.
module rsa_regctrl
  import rsa_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_data_o,
  input  logic       reg_data_o_vld,
  output logic [7:0] reg_data_i,
  output logic [7:0] status,
  output logic [7:0] eng_plain,
  output logic [7:0] eng_exp,
  output logic [7:0] eng_mod,
  output logic [7:0] eng_const,
  output logic       eng_start,
  input  logic       eng_done,
  input  logic [7:0] eng_result,
  output logic       irq
);

  state_e     state_q, state_d;
  logic [7:0] plain_q, plain_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] mod_q, mod_d;
  logic [7:0] const_q, const_d;
  logic [7:0] result_q, result_d;
  logic [7:0] opcount_q, opcount_d;
  logic [7:0] scratch_q, scratch_d;
  logic [7:0] engPlain_q, engPlain_d;
  logic [7:0] engExp_q, engExp_d;
  logic [7:0] engMod_q, engMod_d;
  logic [7:0] engConst_q, engConst_d;
  logic       irqEn_q, irqEn_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       timeoutFlag;
  logic       busy;
  logic       startReq;

`ifdef RSA_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic wdExpired;

  rsa_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .enable_i (state_q == ST_WAIT),
    .clear_i  (state_q != ST_WAIT),
    .expired_o(wdExpired)
  );

  assign timeoutFlag = timeout_q;
`else
  assign timeoutFlag = 1'b0;
`endif

  assign busy     = (state_q != ST_IDLE);
  assign startReq = reg_data_o_vld && (reg_addr == ADDR_CTRL) && reg_data_o[CTRL_START];

  // Next-state: register writes first (CLR), then FSM events, so a
  // completion or a fresh error in the same cycle overrides CLR
  always_comb begin
    state_d    = state_q;
    plain_d    = plain_q;
    exp_d      = exp_q;
    mod_d      = mod_q;
    const_d    = const_q;
    result_d   = result_q;
    opcount_d  = opcount_q;
    scratch_d  = scratch_q;
    engPlain_d = engPlain_q;
    engExp_d   = engExp_q;
    engMod_d   = engMod_q;
    engConst_d = engConst_q;
    irqEn_d    = irqEn_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef RSA_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif

    if (reg_data_o_vld) begin
      unique case (reg_addr)
        ADDR_CTRL: begin
          irqEn_d = reg_data_o[CTRL_IRQEN];
          if (reg_data_o[CTRL_CLR]) begin
            done_d = 1'b0;
            err_d  = 1'b0;
`ifdef RSA_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
          end
        end
        ADDR_PLAIN: begin
          if (busy) err_d = 1'b1;
          else      plain_d = reg_data_o;
        end
        ADDR_EXP: begin
          if (busy) err_d = 1'b1;
          else      exp_d = reg_data_o;
        end
        ADDR_MOD: begin
          if (busy) err_d = 1'b1;
          else      mod_d = reg_data_o;
        end
        ADDR_CONST: begin
          if (busy) err_d = 1'b1;
          else      const_d = reg_data_o;
        end
        ADDR_SCRATCH: begin
          scratch_d = reg_data_o;
        end
        default: begin
          // RESULT and OPCOUNT are read-only; writes are silently dropped
        end
      endcase
    end

    unique case (state_q)
      ST_IDLE: begin
        if (startReq) begin
          state_d    = ST_LAUNCH;
          engPlain_d = plain_q;
          engExp_d   = exp_q;
          engMod_d   = mod_q;
          engConst_d = const_q;
          done_d     = 1'b0;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        if (startReq) err_d = 1'b1;
      end
      ST_WAIT: begin
        if (startReq) err_d = 1'b1;
        if (eng_done) begin
          state_d   = ST_IDLE;
          result_d  = eng_result;
          done_d    = 1'b1;
          opcount_d = opcount_q + 8'd1;
        end
`ifdef RSA_TIMEOUT_EN
        else if (wdExpired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          done_d    = 1'b0;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and register file update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      plain_q    <= 8'h00;
      exp_q      <= 8'h00;
      mod_q      <= 8'h00;
      const_q    <= 8'h00;
      result_q   <= 8'h00;
      opcount_q  <= 8'h00;
      scratch_q  <= 8'h00;
      engPlain_q <= 8'h00;
      engExp_q   <= 8'h00;
      engMod_q   <= 8'h00;
      engConst_q <= 8'h00;
      irqEn_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef RSA_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      plain_q    <= plain_d;
      exp_q      <= exp_d;
      mod_q      <= mod_d;
      const_q    <= const_d;
      result_q   <= result_d;
      opcount_q  <= opcount_d;
      scratch_q  <= scratch_d;
      engPlain_q <= engPlain_d;
      engExp_q   <= engExp_d;
      engMod_q   <= engMod_d;
      engConst_q <= engConst_d;
      irqEn_q    <= irqEn_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef RSA_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign status    = packStatus(busy, done_q, err_q, irqEn_q, timeoutFlag);
  assign eng_start = (state_q == ST_LAUNCH);
  assign eng_plain = engPlain_q;
  assign eng_exp   = engExp_q;
  assign eng_mod   = engMod_q;
  assign eng_const = engConst_q;
  assign irq       = done_q & irqEn_q;

  // Combinational read-back mux for the SPI front-end
  always_comb begin
    reg_data_i = 8'h00;
    unique case (reg_addr)
      ADDR_CTRL:    reg_data_i = status;
      ADDR_PLAIN:   reg_data_i = plain_q;
      ADDR_EXP:     reg_data_i = exp_q;
      ADDR_MOD:     reg_data_i = mod_q;
      ADDR_CONST:   reg_data_i = const_q;
      ADDR_RESULT:  reg_data_i = result_q;
      ADDR_OPCOUNT: reg_data_i = opcount_q;
      ADDR_SCRATCH: reg_data_i = scratch_q;
      default:      reg_data_i = 8'h00;
    endcase
  end

endmodule

// File: doc/rsa_regctrl.md
RSA_REGCTRL -- requirements
Module: rsa_regctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 65535, meaning engine watchdog limit in clk cycles (used only with RSA_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port reg_addr  input  3  register address from SPI register front-end.
REQ-005 SHALL have port reg_data_o  input  8  write data from SPI front-end.
REQ-006 SHALL have port reg_data_o_vld  input  1  one-cycle write strobe.
REQ-007 SHALL have port reg_data_i  output  8  combinational read data for reg_addr.
REQ-008 SHALL have port status  output  8  status byte returned as SPI command-phase response.
REQ-009 SHALL have ports eng_plain, eng_exp, eng_mod, eng_const  output  8 each  operand snapshot to RSA engine.
REQ-010 SHALL have port eng_start  output  1  one-cycle launch pulse to engine.
REQ-011 SHALL have port eng_done  input  1  one-cycle completion pulse from engine.
REQ-012 SHALL have port eng_result  input  8  engine result, valid with eng_done.
REQ-013 SHALL have port irq  output  1  level interrupt = done AND irq_en.

Function
REQ-014 Register map SHALL be: 0 CTRL/STATUS, 1 PLAIN, 2 EXP, 3 MOD, 4 CONST, 5 RESULT (RO), 6 OPCOUNT (RO), 7 SCRATCH (RW).
REQ-015 Status byte SHALL be: [0] busy, [1] done, [2] err, [3] irq_en, [4] timeout, [7:5] zero; reads of addr 0 and port status both return it.
REQ-016 Write to addr 0 SHALL decode: bit0 START (self-clearing), bit1 irq_en (stored), bit2 CLR (write-1 clears done, err, timeout; self-clearing).
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT; busy = 1 in LAUNCH and WAIT.
REQ-018 START written in IDLE at cycle N SHALL move to LAUNCH at N+1 with eng_start=1 for exactly that cycle, operands 1-4 copied to eng_* outputs at the same edge, done cleared.
REQ-019 LAUNCH SHALL move to WAIT unconditionally after one cycle.
REQ-020 eng_done in WAIT at cycle M SHALL, at M+1: capture eng_result into RESULT, set done, return to IDLE, increment OPCOUNT (255 wraps to 0).
REQ-021 eng_done outside WAIT SHALL be ignored.
REQ-022 START while busy, or write to addr 1-4 while busy, SHALL be ignored and set err.
REQ-023 Writes to addr 5 and 6 SHALL be ignored without setting err.
REQ-024 Same-cycle completion (set done) and CLR write SHALL leave done=1; CLR still clears err/timeout.
REQ-025 eng_* outputs SHALL hold their snapshot until the next launch.

Reset
REQ-026 rst SHALL force state IDLE, all registers 0, status 0x00, eng_start 0, eng_* 0, irq 0 on the next rising edge, including mid-operation; a later eng_done is ignored.

Configuration
REQ-027 With RSA_TIMEOUT_EN defined, a counter SHALL count cycles in WAIT; on reaching TIMEOUT_CYC without eng_done, state SHALL return to IDLE with timeout=1, done=0, RESULT and OPCOUNT unchanged.
REQ-028 Without RSA_TIMEOUT_EN, no counter SHALL exist, status[4] SHALL read 0, and WAIT SHALL persist until eng_done or rst.

Structure
REQ-029 Shared package rsa_pkg SHALL hold register address constants, status bit indices, CTRL bit indices and the FSM state enum.
REQ-030 Watchdog SHALL be sub-module rsa_watchdog (enable, clear, expired), instantiated only under RSA_TIMEOUT_EN.

Verification
REQ-031 Write PLAIN=0x05, EXP=0x03, MOD=0x21, CONST=0x04, CTRL=0x01 -> eng_start one cycle after strobe, eng_* = 05/03/21/04, status=0x01.
REQ-032 Engine returns eng_done with eng_result=0x1A -> next cycle RESULT=0x1A, status=0x02, OPCOUNT=1; with irq_en set, irq=1 until CTRL=0x04.
REQ-033 CTRL=0x01 and PLAIN=0x77 written while WAIT -> status err bit set (0x05), eng_plain unchanged, no second eng_start.
REQ-034 OPCOUNT preloaded via 255 completed ops -> next completion gives OPCOUNT=0x00.
REQ-035 rst asserted during WAIT, then eng_done -> status=0x00, RESULT=0x00, OPCOUNT unchanged at 0.
REQ-036 With RSA_TIMEOUT_EN, TIMEOUT_CYC=16, no eng_done -> after 16 WAIT cycles status=0x10, state IDLE; new START accepted.
